sdf_bf_stage: RTL and testbench

- Radix-2 decimation-in-frequency single-path delay-feedback (SDF) butterfly stage controller for the streaming NTT pipeline.
- Sits directly around the stage's external DEPTH-entry shift-register delay line: drives its shift enable and input, and consumes its output.
- Performs the modular add/sub butterfly and sequences fill, butterfly and drain phases.
- Frame = 2*DEPTH coefficients: first half is buffered, second half is combined with the buffered half.

---
 rtl/ntt_pkg.sv | 33 +++
 rtl/mod_addsub.sv | 23 ++
 rtl/sdf_bf_stage.sv | 130 +++++++++++++
 tb/tb_sdf_bf_stage.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// ntt_pkg: definitions shared by the streaming NTT butterfly stages.
//   bf_state_t : stage sequencing state (RUN accepts beats, DRAIN empties the delay line).
//   mod_add    : (a + b) mod q.
//   mod_sub    : (a - b) mod q.
// The functions work on MAXW+1 bits. Callers zero-extend their WIDTH-bit operands
// (WIDTH <= MAXW) and truncate the result back. Operands must already be < q.
package ntt_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } bf_state_t;

    localparam int MAXW = 32;

    typedef logic [MAXW:0] wide_t;

    function automatic wide_t mod_add(input wide_t a, input wide_t b, input wide_t q);
        wide_t s;
        s = a + b;
        if (s >= q) s = s - q;
        return s;
    endfunction

    function automatic wide_t mod_sub(input wide_t a, input wide_t b, input wide_t q);
        wide_t d;
        // Add q before subtracting, so the unsigned result never wraps.
        if (a >= b) d = a - b;
        else        d = a + q - b;
        return d;
    endfunction

endpackage

// File: rtl/mod_addsub.sv
// mod_addsub: combinational modular butterfly core, shared by all NTT stages.
//   i_a, i_b : operands, both < Q.
//   o_sum    : (i_a + i_b) mod Q.
//   o_diff   : (i_a - i_b) mod Q.
module mod_addsub
    import ntt_pkg::*;
#(
    parameter int          WIDTH = 16,
    parameter int unsigned Q     = 12289
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum,
    output logic [WIDTH-1:0] o_diff
);

    localparam wide_t QW = wide_t'(Q);

    // Both results are < Q < 2^WIDTH, so truncating drops only zero bits.
    assign o_sum  = WIDTH'(mod_add(wide_t'(i_a), wide_t'(i_b), QW));
    assign o_diff = WIDTH'(mod_sub(wide_t'(i_a), wide_t'(i_b), QW));

endmodule

// File: rtl/sdf_bf_stage.sv
// sdf_bf_stage: radix-2 DIF single-path delay-feedback butterfly stage controller.
// It wraps an external DEPTH-entry shift-register delay line. A frame is 2*DEPTH beats.
// During the first half (fill), the input is buffered and the previous frame's
// differences come out of the line. During the second half (butterfly), sums are
// emitted and differences go back into the line. A flush drains the buffered
// differences at the next frame boundary.
//   clk, rst   : clock; asynchronous active-low reset.
//   in_valid   : input beat valid.    in_ready  : beat accepted this cycle (comb).
//   in_data    : input coefficient.   flush     : drain request pulse (remembered).
//   out_valid  : registered valid.    out_data  : registered coefficient.
//   draining   : high while in DRAIN.
//   fifo_shift : delay-line shift enable (comb).
//   fifo_din   : delay-line input (comb).
//   fifo_dout  : oldest delay-line entry.
module sdf_bf_stage
    import ntt_pkg::*;
#(
    parameter int          WIDTH = 16,
    parameter int          DEPTH = 8,
    parameter int unsigned Q     = 12289
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             draining,
    output logic             fifo_shift,
    output logic [WIDTH-1:0] fifo_din,
    input  logic [WIDTH-1:0] fifo_dout
);

    localparam int             CW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEPTH - 1);

    bf_state_t        r_st;
    logic             r_phase;       // 0 = fill, 1 = butterfly
    logic [CW-1:0]    r_cnt;
    logic             r_primed;      // line holds a complete frame of differences
    logic             r_flush_pend;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_boundary;
    logic             w_drain_start;
    logic             w_accept;
    logic             w_cnt_last;

    // a = oldest buffered value, b = new beat
    mod_addsub #(
        .WIDTH (WIDTH),
        .Q     (Q)
    ) u_mod_addsub (
        .i_a    (fifo_dout),
        .i_b    (in_data),
        .o_sum  (w_sum),
        .o_diff (w_diff)
    );

    assign w_boundary    = !r_phase && (r_cnt == '0);
    assign w_drain_start = (flush || r_flush_pend) && r_primed && w_boundary && (r_st == RUN);
    assign w_cnt_last    = (r_cnt == CNT_LAST);

    // A drain that starts now takes priority over an incoming beat. The source retries.
    assign in_ready   = (r_st == RUN) && !w_drain_start;
    assign w_accept   = in_valid && in_ready;
    assign fifo_shift = w_accept || (r_st == DRAIN);

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign draining  = (r_st == DRAIN);

    always_comb begin
        // NOTE: default first, so every path assigns fifo_din and no latch is inferred.
        fifo_din = in_data;
        if (r_st == DRAIN) fifo_din = '0;
        else if (r_phase)  fifo_din = w_diff;
    end

    // NOTE: the delay line is not cleared on reset. r_primed = 0 masks its stale contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_st         <= RUN;
            r_phase      <= 1'b0;
            r_cnt        <= '0;
            r_primed     <= 1'b0;
            r_flush_pend <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
        end else begin
            // NOTE: non-blocking assignments only, so every register sees pre-edge values.
            if (r_st == DRAIN) begin
                r_out_valid <= 1'b1;
                r_out_data  <= fifo_dout;
                if (w_cnt_last) begin
                    r_cnt    <= '0;
                    r_primed <= 1'b0;
                    r_st     <= RUN;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (w_accept) begin
                // Fill emits the previous frame's differences. Butterfly emits sums.
                r_out_valid <= r_phase ? 1'b1 : r_primed;
                r_out_data  <= r_phase ? w_sum : fifo_dout;
                if (w_cnt_last) begin
                    r_cnt   <= '0;
                    r_phase <= ~r_phase;
                    if (r_phase) r_primed <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_out_valid <= 1'b0;
                if (w_drain_start) r_st <= DRAIN;
            end

            // Any RUN boundary resolves a pending flush. It starts a drain if primed,
            // otherwise the flush has no effect.
            if ((r_st == RUN) && w_boundary) r_flush_pend <= 1'b0;
            else if (flush)                  r_flush_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdf_bf_stage.sv
// Self-checking bench for sdf_bf_stage (WIDTH=5, DEPTH=2, Q=17).
// It contains the external delay line and a frame-level reference model.
module tb_sdf_bf_stage;

    localparam int W = 5;
    localparam int D = 2;
    localparam int Q = 17;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         flush = 1'b0;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         draining;
    logic         fifo_shift;
    logic [W-1:0] fifo_din;
    logic [W-1:0] fifo_dout;

    int tests = 0;
    int fails = 0;

    sdf_bf_stage #(.WIDTH(W), .DEPTH(D), .Q(Q)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .draining   (draining),
        .fifo_shift (fifo_shift),
        .fifo_din   (fifo_din),
        .fifo_dout  (fifo_dout)
    );

    always #5 clk = ~clk;

    // External delay line; never reset.
    logic [W-1:0] dl [D];
    assign fifo_dout = dl[D-1];
    always @(posedge clk) begin
        if (fifo_shift) begin
            for (int i = D - 1; i > 0; i--) dl[i] <= dl[i-1];
            dl[0] <= fifo_din;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Observation logs used by the directed scenarios.
    int out_log[$];
    int din_log[$];
    int drain_cnt = 0;

    task automatic clear_logs();
        out_log.delete();
        din_log.delete();
        drain_cnt = 0;
    endtask

    task automatic check_q(input string name, input int act[$], input int exp[$]);
        string sa, se;
        bit ok;
        ok = (act.size() == exp.size());
        for (int i = 0; ok && i < act.size(); i++) if (act[i] != exp[i]) ok = 0;
        tests++;
        if (!ok) begin
            fails++;
            sa = ""; se = "";
            foreach (act[i]) sa = {sa, $sformatf(" %0d", act[i])};
            foreach (exp[i]) se = {se, $sformatf(" %0d", exp[i])};
            $display("FAIL %s: got {%s } expected {%s }", name, sa, se);
        end
    endtask

    // Reference model. line[] holds the delay-line contents, oldest first.
    // Entries of -1 are unknown; they are never compared.
    int line[$] = '{-1, -1};
    bit m_drain = 0;
    int m_dcnt = 0;
    int m_pos = 0;      // position in frame, 0 .. 2D-1
    bit m_primed = 0;
    bit m_pend = 0;
    bit exp_ov = 0;
    int exp_od = 0;

    always @(negedge clk) begin
        if (!rst) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_out_data", out_data, 0);
            m_drain = 0; m_dcnt = 0; m_pos = 0; m_primed = 0; m_pend = 0; exp_ov = 0;
        end else begin
            automatic bit bnd, ds, acc, e_shift;
            automatic int e_din, a, b;
            check("out_valid", out_valid, exp_ov);
            if (exp_ov) check("out_data", out_data, exp_od);
            if (out_valid)  out_log.push_back(int'(out_data));
            if (fifo_shift) din_log.push_back(int'(fifo_din));
            if (draining)   drain_cnt++;

            bnd = !m_drain && (m_pos == 0);
            ds  = (flush || m_pend) && m_primed && bnd;
            check("in_ready", in_ready, !m_drain && !ds);
            check("draining", draining, m_drain);
            acc = in_valid && !m_drain && !ds;

            e_shift = 0; e_din = 0; exp_ov = 0;
            if (m_drain) begin
                e_shift = 1;
                a = line.pop_front();
                line.push_back(0);
                exp_ov = 1; exp_od = a;
                m_dcnt++;
                if (m_dcnt == D) begin
                    m_drain = 0; m_dcnt = 0; m_primed = 0;
                end
            end else if (acc) begin
                e_shift = 1;
                a = line.pop_front();
                b = int'(in_data);
                if (m_pos < D) begin
                    e_din = b; exp_ov = m_primed; exp_od = a;
                end else begin
                    e_din = (a - b + Q) % Q; exp_ov = 1; exp_od = (a + b) % Q;
                end
                line.push_back(e_din);
                m_pos++;
                if (m_pos == 2 * D) begin
                    m_pos = 0; m_primed = 1;
                end
            end
            check("fifo_shift", fifo_shift, e_shift);
            if (e_shift) check("fifo_din", fifo_din, e_din);

            if (ds) m_drain = 1;
            if (bnd)        m_pend = 0;
            else if (flush) m_pend = 1;
        end
    end

    // Drivers. Every task starts and ends 1 time unit after a rising edge.
    task automatic send(input int v, input bit f, output int stalls);
        bit r;
        stalls = 0;
        in_valid = 1'b1;
        in_data  = W'(v);
        flush    = f;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk) r = in_ready;
            @(posedge clk);
            #1;
            flush = 1'b0;
            if (r) return;
            stalls++;
        end
        check("send_timeout", 1, 0);
    endtask

    task automatic send_frame(input int v0, input int v1, input int v2, input int v3);
        int s;
        send(v0, 0, s); send(v1, 0, s); send(v2, 0, s); send(v3, 0, s);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_flush();
        in_valid = 1'b0;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_draining", draining, 0);
        check("reset_fifo_shift", fifo_shift, 0);
        rst = 1'b1;
        idle(1);

        // Scenario 1: frame 1,2,3,4, then flush.
        clear_logs();
        send_frame(1, 2, 3, 4);
        pulse_flush();
        idle(4);
        check_q("s1_out", out_log, '{4, 6, 15, 15});
        check_q("s1_din", din_log, '{1, 2, 15, 15, 0, 0});
        check("s1_drain_cycles", drain_cnt, D);
        // primed is now 0, so a further flush is a no-op.
        clear_logs();
        pulse_flush();
        idle(4);
        check("s1_noop_drain", drain_cnt, 0);

        // Scenario 2: wrap arithmetic.
        clear_logs();
        send_frame(0, 0, 16, 16);
        send_frame(16, 16, 16, 16);
        idle(1);
        pulse_flush();
        idle(4);
        check_q("s2_out", out_log, '{16, 16, 1, 1, 15, 15, 0, 0});
        check_q("s2_din", din_log, '{0, 0, 1, 1, 16, 16, 0, 0, 0, 0});

        // Scenario 3: back-to-back frames.
        clear_logs();
        send_frame(1, 2, 3, 4);
        send_frame(5, 6, 7, 8);
        pulse_flush();
        idle(4);
        check_q("s3_out", out_log, '{4, 6, 15, 15, 12, 14, 15, 15});
        check_q("s3_din", din_log, '{1, 2, 15, 15, 5, 6, 15, 15, 0, 0});

        // Scenario 4: a 3-cycle gap in the middle of phase 1.
        clear_logs();
        send(1, 0, s); send(2, 0, s); send(3, 0, s);
        idle(3);
        send(4, 0, s);
        pulse_flush();
        idle(4);
        check_q("s4_out", out_log, '{4, 6, 15, 15});
        check_q("s4_din", din_log, '{1, 2, 15, 15, 0, 0});

        // Scenario 5: flush on the last beat of phase 1 waits for the boundary.
        clear_logs();
        send(1, 0, s); send(2, 0, s); send(3, 0, s);
        send(4, 1, s);
        check("s5_no_stall", s, 0);
        idle(5);
        check("s5_drain_cycles", drain_cnt, D);
        check_q("s5_out", out_log, '{4, 6, 15, 15});

        // Scenario 6: asynchronous reset in phase 1.
        send(1, 0, s); send(2, 0, s); send(3, 0, s);
        in_valid = 1'b0;
        check("s6_pre_valid", out_valid, 1);
        check("s6_pre_data", out_data, 4);
        #2 rst = 1'b0;
        #1;
        check("s6_async_valid", out_valid, 0);
        check("s6_async_data", out_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(1);
        clear_logs();
        flush = 1'b1;
        #3;
        check("s6_flush_noop_ready", in_ready, 1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        idle(3);
        check("s6_flush_noop_drain", drain_cnt, 0);
        send_frame(1, 2, 3, 4);
        pulse_flush();
        idle(4);
        check_q("s6_out", out_log, '{4, 6, 15, 15});

        // Randomized traffic, checked by the model on every cycle.
        for (int c = 0; c < 2000; c++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            in_data  = W'($urandom_range(0, Q - 1));
            flush    = ($urandom_range(0, 29) == 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        flush = 1'b0;
        idle(8);
        pulse_flush();
        idle(8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
